// File: rtl/audvid_pkg.sv
// Shared constants for the AudVid peripheral: SD block geometry, the
// default silence word and the stereo field layout of a packed sample.
package audvid_pkg;

    localparam logic [31:0] SILENCE_DEFAULT     = 32'h0000_0000;
    localparam int          SD_BLOCK_BYTES      = 512;
    localparam int          BLOCK_WORDS_DEFAULT = SD_BLOCK_BYTES / 4;

    // Stereo sample layout: left channel in the upper half, right in the lower.
    localparam int LEFT_MSB  = 31;
    localparam int RIGHT_MSB = 15;

    // Bytes arrive as little-endian 16-bit PCM: b0/b1 form left, b2/b3 right.
    function automatic logic [31:0] pack_stereo(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2,
                                                input logic [7:0] b3);
        logic [31:0] w;
        w = '0;
        w[LEFT_MSB -: 16]  = {b1, b0};
        w[RIGHT_MSB -: 16] = {b3, b2};
        return w;
    endfunction

endpackage

// File: rtl/audio_sample_buffer_if.sv
// Signal bundle between the sample buffer and its neighbours: the SD byte
// stream and block throttle on one side, the I2S sample handshake on the other.
// Handshake: ByteValid and SampleRequest are single-cycle strobes with no
// back-pressure; the buffer never stalls them. SampleValid pulses exactly one
// cycle after each accepted SampleRequest, and BlockRequest gates block starts.
interface audio_sample_buffer_if #(
    parameter int DEPTH_LOG2 = 8
);
    logic [7:0]          ByteData;
    logic                ByteValid;
    logic                Flush;
    logic                BlockRequest;
    logic                SampleRequest;
    logic [31:0]         SampleData;
    logic                SampleValid;
    logic [DEPTH_LOG2:0] Level;
    logic                Underrun;
    logic                Overflow;

    // Producer/consumer side that drives bytes and requests.
    modport master (
        output ByteData, ByteValid, Flush, SampleRequest,
        input  BlockRequest, SampleData, SampleValid, Level, Underrun, Overflow
    );

    // The buffer itself.
    modport slave (
        input  ByteData, ByteValid, Flush, SampleRequest,
        output BlockRequest, SampleData, SampleValid, Level, Underrun, Overflow
    );
endinterface

// File: rtl/audio_sample_buffer_sync_fifo.sv
// Single-clock FIFO with registered read port and a separate level counter.
// A pop on a full FIFO frees the slot in the same cycle, so a simultaneous
// push is accepted. Clear wins over push and pop.
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_data,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_push_ok,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic [DEPTH_LOG2:0]   o_level_next
);
    localparam int                    DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_MAX = DEPTH;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [WIDTH-1:0]      r_data;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LVL_MAX);
    assign w_pop_ok  = i_pop & ~o_empty & ~i_clr;
    assign w_push_ok = i_push & ~i_clr & (~o_full | w_pop_ok);
    assign o_push_ok = w_push_ok;
    assign o_level   = r_level;
    assign o_data    = r_data;

    // Next occupancy, also used by the owner to derive throttle signals.
    always_comb begin
        o_level_next = r_level;
        if (i_clr)
            o_level_next = '0;
        else if (w_push_ok && !w_pop_ok)
            o_level_next = r_level + LVL_ONE;
        else if (!w_push_ok && w_pop_ok)
            o_level_next = r_level - LVL_ONE;
    end

    // Storage array write port; no reset so it maps onto RAM.
    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers, level and the registered read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_data   <= '0;
        end else begin
            r_level <= o_level_next;
            if (i_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok)
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    r_data   <= r_mem[r_rd_ptr];
                end
            end
        end
    end

endmodule

// File: rtl/audio_sample_buffer.sv
// Packs SD payload bytes into stereo words, queues them in a FIFO and hands
// one word to the I2S stage per request, substituting silence on underrun.
// BlockRequest throttles the SD reader so a whole block always fits.
module audio_sample_buffer
    import audvid_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 8,
    parameter int          BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
    parameter logic [31:0] SILENCE     = SILENCE_DEFAULT
) (
    input logic                   MasterCLK,
    input logic                   Reset,
    audio_sample_buffer_if.slave  bus
);
    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_MAX = DEPTH;

    logic [1:0]          r_lane;
    logic [7:0]          r_b0;
    logic [7:0]          r_b1;
    logic [7:0]          r_b2;
    logic                r_use_silence;
    logic                r_sample_valid;
    logic                r_underrun;
    logic                r_overflow;
    logic                r_block_req;

    logic                w_word_done;
    logic                w_req;
    logic [31:0]         w_word;
    logic [31:0]         w_fifo_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push_ok;
    logic [DEPTH_LOG2:0] w_level;
    logic [DEPTH_LOG2:0] w_level_next;
    logic [DEPTH_LOG2:0] w_free_next;

    // Flush suppresses same-cycle bytes and requests entirely.
    assign w_word_done = bus.ByteValid & ~bus.Flush & (r_lane == 2'd3);
    assign w_req       = bus.SampleRequest & ~bus.Flush;
    assign w_word      = pack_stereo(r_b0, r_b1, r_b2, bus.ByteData);
    assign w_free_next = LVL_MAX - w_level_next;

    sync_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk        (MasterCLK),
        .i_rst_n      (Reset),
        .i_clr        (bus.Flush),
        .i_push       (w_word_done),
        .i_pop        (w_req),
        .i_data       (w_word),
        .o_data       (w_fifo_data),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_push_ok    (w_push_ok),
        .o_level      (w_level),
        .o_level_next (w_level_next)
    );

    // Byte lane: collect the first three bytes; the fourth goes straight in.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            r_lane <= '0;
            r_b0   <= '0;
            r_b1   <= '0;
            r_b2   <= '0;
        end else if (bus.Flush) begin
            r_lane <= '0;
        end else if (bus.ByteValid) begin
            case (r_lane)
                2'd0:    r_b0 <= bus.ByteData;
                2'd1:    r_b1 <= bus.ByteData;
                2'd2:    r_b2 <= bus.ByteData;
                default: ;
            endcase
            r_lane <= r_lane + 2'd1;
        end
    end

    // Output side: silence select, valid pulse, sticky flags and throttle.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            r_use_silence  <= 1'b1;
            r_sample_valid <= 1'b0;
            r_underrun     <= 1'b0;
            r_overflow     <= 1'b0;
            r_block_req    <= 1'b1;
        end else begin
            r_sample_valid <= w_req;
            r_block_req    <= (int'(w_free_next) >= BLOCK_WORDS);
            if (w_req)
                r_use_silence <= w_fifo_empty;
            if (bus.Flush) begin
                r_underrun <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_req && w_fifo_empty)
                    r_underrun <= 1'b1;
                if (w_word_done && w_fifo_full && !w_push_ok)
                    r_overflow <= 1'b1;
            end
        end
    end

    assign bus.SampleData   = r_use_silence ? SILENCE : w_fifo_data;
    assign bus.SampleValid  = r_sample_valid;
    assign bus.Level        = w_level;
    assign bus.Underrun     = r_underrun;
    assign bus.Overflow     = r_overflow;
    assign bus.BlockRequest = r_block_req;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer with hand-computed expectations.
module tb_audio_sample_buffer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    audio_sample_buffer_if #(.DEPTH_LOG2(8)) bus ();

    audio_sample_buffer #(
        .DEPTH_LOG2  (8),
        .BLOCK_WORDS (128),
        .SILENCE     (32'h0000_0000)
    ) dut (
        .MasterCLK (clk),
        .Reset     (rst_n),
        .bus       (bus)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One byte strobe, optionally with a sample request in the same cycle.
    task automatic send_byte(input logic [7:0] b, input logic req);
        bus.ByteData      = b;
        bus.ByteValid     = 1'b1;
        bus.SampleRequest = req;
        tick();
        bus.ByteValid     = 1'b0;
        bus.SampleRequest = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        send_byte(b3, 1'b0);
    endtask

    task automatic request();
        bus.SampleRequest = 1'b1;
        tick();
        bus.SampleRequest = 1'b0;
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        rst_n             = 1'b1;
        bus.ByteData      = '0;
        bus.ByteValid     = 1'b0;
        bus.Flush         = 1'b0;
        bus.SampleRequest = 1'b0;

        // Reset
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_data",  bus.SampleData, 32'h0);
        check("rst_valid", 32'(bus.SampleValid), 32'd0);
        check("rst_level", 32'(bus.Level), 32'd0);
        check("rst_under", 32'(bus.Underrun), 32'd0);
        check("rst_over",  32'(bus.Overflow), 32'd0);
        check("rst_blkreq", 32'(bus.BlockRequest), 32'd1);
        rst_n = 1'b1;
        tick();

        // Basic pack and read
        send_word(8'h34, 8'h12, 8'h78, 8'h56);
        check("pack_level", 32'(bus.Level), 32'd1);
        request();
        check("pack_data",  bus.SampleData, 32'h1234_5678);
        check("pack_valid", 32'(bus.SampleValid), 32'd1);
        check("pack_level0", 32'(bus.Level), 32'd0);
        tick();
        check("valid_pulse", 32'(bus.SampleValid), 32'd0);
        check("data_hold",  bus.SampleData, 32'h1234_5678);

        // Underrun on empty
        request();
        check("udr_data",  bus.SampleData, 32'h0);
        check("udr_valid", 32'(bus.SampleValid), 32'd1);
        check("udr_flag",  32'(bus.Underrun), 32'd1);
        check("udr_level", 32'(bus.Level), 32'd0);
        tick();
        check("udr_sticky", 32'(bus.Underrun), 32'd1);
        check("udr_hold",  bus.SampleData, 32'h0);
        send_word(8'h01, 8'h02, 8'h03, 8'h04);
        request();
        check("after_udr_data", bus.SampleData, 32'h0201_0403);
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        check("flush_under", 32'(bus.Underrun), 32'd0);

        // Fill to full; word i = {A5, i, 5A, ~i}
        for (int i = 0; i < 256; i++) begin
            send_word(8'(i), 8'hA5, ~8'(i), 8'h5A);
            if (i == 127) begin
                check("lvl128", 32'(bus.Level), 32'd128);
                check("blkreq128", 32'(bus.BlockRequest), 32'd1);
            end
            if (i == 128) begin
                check("lvl129", 32'(bus.Level), 32'd129);
                check("blkreq129", 32'(bus.BlockRequest), 32'd0);
            end
        end
        check("full_level", 32'(bus.Level), 32'd256);
        check("full_over",  32'(bus.Overflow), 32'd0);

        // Push and pop together at full
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b1);
        check("fullpp_data",  bus.SampleData, 32'hA500_5AFF);
        check("fullpp_level", 32'(bus.Level), 32'd256);
        check("fullpp_over",  32'(bus.Overflow), 32'd0);

        // Overflow: word dropped, head intact
        send_word(8'h01, 8'h02, 8'h03, 8'h04);
        check("ovf_flag",  32'(bus.Overflow), 32'd1);
        check("ovf_level", 32'(bus.Level), 32'd256);
        request();
        check("ovf_head", bus.SampleData, 32'hA501_5AFE);
        check("ovf_level2", 32'(bus.Level), 32'd255);

        // Flush mid-word
        send_byte(8'hEE, 1'b0);
        send_byte(8'hFF, 1'b0);
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        check("flush_level", 32'(bus.Level), 32'd0);
        check("flush_over",  32'(bus.Overflow), 32'd0);
        check("flush_blkreq", 32'(bus.BlockRequest), 32'd1);
        check("flush_hold",  bus.SampleData, 32'hA501_5AFE);
        send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        check("postflush_level", 32'(bus.Level), 32'd1);
        request();
        check("postflush_data", bus.SampleData, 32'hBBAA_DDCC);

        // Push and pop together on empty
        send_byte(8'h01, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h45, 1'b0);
        send_byte(8'h67, 1'b1);
        check("emptypp_data",  bus.SampleData, 32'h0);
        check("emptypp_valid", 32'(bus.SampleValid), 32'd1);
        check("emptypp_under", 32'(bus.Underrun), 32'd1);
        check("emptypp_level", 32'(bus.Level), 32'd1);
        request();
        check("emptypp_kept", bus.SampleData, 32'h2301_6745);

        // Asynchronous reset between edges, mid-word
        send_word(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        send_byte(8'h99, 1'b0);
        send_byte(8'h98, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_level", 32'(bus.Level), 32'd0);
        check("arst_under", 32'(bus.Underrun), 32'd0);
        check("arst_data",  bus.SampleData, 32'h0);
        check("arst_valid", 32'(bus.SampleValid), 32'd0);
        check("arst_blkreq", 32'(bus.BlockRequest), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send_word(8'h10, 8'h20, 8'h30, 8'h40);
        request();
        check("arst_lane", bus.SampleData, 32'h2010_4030);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_sample_buffer.md
# audio_sample_buffer

Buffers PCM audio between the SD card byte stream and the I2S transmitter inside the AudVid peripheral. Packs little-endian bytes from the SD reader into 32-bit stereo samples and stores them in a synchronous FIFO. Hands one sample to the I2S stage per sample request. Throttles the SD reader per 512-byte block and substitutes silence on underrun.

## Interface
Parameters:
- DEPTH_LOG2, default 8: FIFO depth of 2^DEPTH_LOG2 32-bit words.
- BLOCK_WORDS, default 128: words per SD block (512 bytes).
- SILENCE, default 32'h0000_0000: word driven on underrun.

Ports:
- MasterCLK  in  1  sole clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ByteData  in  8  SD payload byte.
- ByteValid  in  1  one-cycle strobe qualifying ByteData, already synchronous to MasterCLK.
- Flush  in  1  synchronous clear of FIFO, byte lane and sticky flags.
- BlockRequest  out  1  high when free space ≥ BLOCK_WORDS; SD reader starts a block only while high.
- SampleRequest  in  1  one-cycle strobe from the I2S stage (word-select edge, pre-synchronised).
- SampleData  out  32  [31:16] left, [15:0] right; held between requests.
- SampleValid  out  1  one-cycle pulse, one cycle after SampleRequest.
- Level  out  DEPTH_LOG2+1  words currently stored.
- Underrun  out  1  sticky; set when a request finds the FIFO empty.
- Overflow  out  1  sticky; set when a completed word finds the FIFO full.

## Operation
- Byte lane: 2-bit counter `lane`. Each ByteValid writes ByteData into a byte register selected by lane, then lane increments and wraps 3→0.
- Packing: bytes b0,b1,b2,b3 form the word {b1,b0,b3,b2}, i.e. left = {b1,b0}, right = {b3,b2}, 16-bit little-endian PCM.
- Write: on the ByteValid with lane==3, the assembled word (b3 taken directly from ByteData) is pushed if Level < 2^DEPTH_LOG2. If the FIFO is full, the word is dropped, Overflow is set, and lane still wraps to 0.
- Read: on SampleRequest with Level > 0, SampleData ← mem[rd_ptr] and rd_ptr increments. With Level == 0, SampleData ← SILENCE, Underrun is set, and no pointers move. SampleValid pulses in both cases.
- Simultaneous push and pop: both occur and Level is unchanged. When Level==0, the pop sees empty: silence is output and the pushed word is kept. When the FIFO is full, the pop frees a slot in the same cycle, so the push is accepted.
- Pointers are DEPTH_LOG2 bits and wrap naturally. Level is a separate up/down counter of width DEPTH_LOG2+1.
- BlockRequest ← (2^DEPTH_LOG2 − Level_next) ≥ BLOCK_WORDS, registered.
- Flush: pointers, Level, lane, Underrun and Overflow go to 0. SampleData keeps its value. Flush has priority over a same-cycle ByteValid or SampleRequest, which are ignored.
- Reset values: SampleData=SILENCE, SampleValid=0, Level=0, Underrun=0, Overflow=0, BlockRequest=1. Pointers and lane are 0. Reset asserted mid-word discards the partial word.

## Timing
- Byte to stored word: the 4th ByteValid edge writes memory, and Level increments on the same edge.
- Request to data: SampleData and SampleValid are updated on the edge after SampleRequest is sampled, a fixed latency of 1 cycle.
- A word written at edge N is readable by a SampleRequest sampled at edge N+1 or later.
- BlockRequest reflects the post-edge Level, with no extra cycle of lag.
- Back-to-back ByteValid and SampleRequest on every cycle are supported.
- Memory is a single-clock dual-port register array with registered read, inferable as distributed RAM or BRAM.

## Structure
- Shared package audvid_pkg holds:
  - the SILENCE default,
  - the SD block size (512 bytes) and derived BLOCK_WORDS,
  - stereo field positions (LEFT_MSB=31, RIGHT_MSB=15).
- One natural sub-module, sync_fifo: parameterised width and depth, with push/pop, full/empty and level. It is reusable for the tile path.
- audio_sample_buffer contains the byte packer, the underrun/silence mux and the sticky flags around sync_fifo.

## Test plan
- Reset, then feed bytes 34 12 78 56 → Level=1. A SampleRequest returns SampleData=32'h1234_5678 and a SampleValid pulse one cycle later.
- Issue SampleRequest with an empty FIFO → SampleData=32'h0, Underrun=1 and held, Level stays 0. A following valid word reads out correctly.
- Push 256 words; check BlockRequest drops at Level=129. Push 4 more bytes → Overflow=1, Level=256, the first word read back is unchanged.
- At Level=256, push and pop in the same cycle → push accepted, Level stays 256, no Overflow. At Level=0, same-cycle push and pop → silence returned, Level becomes 1.
- Pulse Flush after 2 bytes of a word → Level=0, flags clear. The next 4 bytes AA BB CC DD read as 32'hBBAA_DDCC.
- Assert Reset asynchronously mid-stream between clock edges → all outputs reach their reset values immediately, with BlockRequest=1.
